// File: rtl/weight_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | weight_loader: streams host weight bytes into a NUM_WEIGHTS-entry memory  |
// | with inter-byte timeout and sticky protocol error.  Rev 1.0               |
// +--------------------------------------------------------------------------+
module weight_loader #(
  parameter int NUM_WEIGHTS    = 4,
  parameter int ADDR_W         = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              host_valid,
  input  logic [7:0]        host_data,
  output logic              host_ready,
  output logic              mem_ctrl_en,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        rpi_weights,
  output logic              busy,
  output logic              load_done,
  output logic              weights_valid,
  output logic              error
);

  localparam logic [ADDR_W-1:0] c_last_idx   = ADDR_W'(NUM_WEIGHTS - 1);
  localparam logic [15:0]       c_timer_last = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_count, w_count_nxt;
  logic [15:0]       r_timer, w_timer_nxt;

  logic              w_mem_en_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [7:0]        w_data_nxt;
  logic              w_done_nxt;
  logic              w_wvalid_nxt;
  logic              w_error_nxt;
  logic              w_accept;
  logic              w_drop;

  // host_ready is the registered image of "state is LOAD", so it gates acceptance directly
  assign w_accept = host_valid && host_ready;
  assign w_drop   = host_valid && !host_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_timer_nxt  = r_timer;
    w_mem_en_nxt = 1'b0;
    w_addr_nxt   = addr;
    w_data_nxt   = rpi_weights;
    w_done_nxt   = 1'b0;
    w_wvalid_nxt = weights_valid;
    w_error_nxt  = error;

    case (r_state)
      S_IDLE: begin
        if (load_start) begin
          w_state_nxt  = S_LOAD;
          w_count_nxt  = '0;
          w_timer_nxt  = '0;
          w_wvalid_nxt = 1'b0;
          w_error_nxt  = 1'b0;
        end
      end
      S_LOAD: begin
        // an accepted byte beats a timer expiring in the same cycle
        if (w_accept) begin
          w_mem_en_nxt = 1'b1;
          w_addr_nxt   = r_count;
          w_data_nxt   = host_data;
          w_timer_nxt  = '0;
          w_count_nxt  = r_count + 1'b1;
          if (r_count == c_last_idx) begin
            w_state_nxt = S_DONE;
          end
        end else if (r_timer == c_timer_last) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
          w_timer_nxt = '0;
          w_error_nxt = 1'b1;
          w_wvalid_nxt = 1'b0;
        end else begin
          w_timer_nxt = r_timer + 16'd1;
        end
      end
      S_DONE: begin
        w_state_nxt  = S_IDLE;
        w_done_nxt   = 1'b1;
        w_wvalid_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // a dropped byte flags an error even when a start clears it in the same cycle
    if (w_drop) begin
      w_error_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_timer       <= '0;
      host_ready    <= 1'b0;
      mem_ctrl_en   <= 1'b0;
      addr          <= '0;
      rpi_weights   <= '0;
      busy          <= 1'b0;
      load_done     <= 1'b0;
      weights_valid <= 1'b0;
      error         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_count       <= w_count_nxt;
      r_timer       <= w_timer_nxt;
      host_ready    <= (w_state_nxt == S_LOAD);
      mem_ctrl_en   <= w_mem_en_nxt;
      addr          <= w_addr_nxt;
      rpi_weights   <= w_data_nxt;
      busy          <= (w_state_nxt != S_IDLE);
      load_done     <= w_done_nxt;
      weights_valid <= w_wvalid_nxt;
      error         <= w_error_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_weight_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_weight_loader: directed + randomized bench with behavioural model.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_weight_loader;

  localparam int NW = 4;
  localparam int AW = 2;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic          host_valid = 1'b0;
  logic [7:0]    host_data = 8'h00;
  logic          host_ready;
  logic          mem_ctrl_en;
  logic [AW-1:0] addr;
  logic [7:0]    rpi_weights;
  logic          busy;
  logic          load_done;
  logic          weights_valid;
  logic          error;

  int checks = 0;
  int errors = 0;

  weight_loader #(
    .NUM_WEIGHTS    (NW),
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .load_start    (load_start),
    .host_valid    (host_valid),
    .host_data     (host_data),
    .host_ready    (host_ready),
    .mem_ctrl_en   (mem_ctrl_en),
    .addr          (addr),
    .rpi_weights   (rpi_weights),
    .busy          (busy),
    .load_done     (load_done),
    .weights_valid (weights_valid),
    .error         (error)
  );

  always #5 clk = ~clk;

  // Behavioural reference: a load is "in progress" or "finishing"; bytes and idle gaps are counted.
  bit            m_loading, m_finishing;
  bit            m_ready, m_en, m_busy, m_done, m_wv, m_err;
  int            m_n, m_idle;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_data;
  logic [7:0]    m_mem   [NW];
  logic [7:0]    dut_mem [NW];

  task automatic model_edge(input bit r, input bit ls, input bit hv, input logic [7:0] hd);
    bit drop;
    drop   = hv && !m_ready;
    m_en   = 1'b0;
    m_done = 1'b0;
    if (r) begin
      m_loading = 0; m_finishing = 0; m_n = 0; m_idle = 0;
      m_addr = '0; m_data = '0; m_wv = 0; m_err = 0;
    end else begin
      if (m_finishing) begin
        m_finishing = 0; m_done = 1; m_wv = 1;
      end else if (m_loading) begin
        if (hv) begin
          m_en = 1; m_addr = AW'(m_n); m_data = hd; m_mem[m_n] = hd;
          m_n++; m_idle = 0;
          if (m_n == NW) begin
            m_loading = 0; m_finishing = 1; m_n = 0;
          end
        end else begin
          m_idle++;
          if (m_idle == TO) begin
            m_loading = 0; m_err = 1; m_idle = 0; m_n = 0;
          end
        end
      end else if (ls) begin
        m_loading = 1; m_n = 0; m_idle = 0; m_wv = 0; m_err = 0;
      end
      if (drop) m_err = 1;
    end
    m_ready = m_loading;
    m_busy  = m_loading || m_finishing;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all();
    if (mem_ctrl_en === 1'b1) dut_mem[addr] = rpi_weights;
    check("host_ready",    32'(host_ready),    32'(m_ready));
    check("mem_ctrl_en",   32'(mem_ctrl_en),   32'(m_en));
    check("addr",          32'(addr),          32'(m_addr));
    check("rpi_weights",   32'(rpi_weights),   32'(m_data));
    check("busy",          32'(busy),          32'(m_busy));
    check("load_done",     32'(load_done),     32'(m_done));
    check("weights_valid", 32'(weights_valid), 32'(m_wv));
    check("error",         32'(error),         32'(m_err));
    if (m_done) begin
      for (int i = 0; i < NW; i++)
        check($sformatf("mem[%0d]", i), 32'(dut_mem[i]), 32'(m_mem[i]));
    end
  endtask

  task automatic cyc(input bit ls, input bit hv, input logic [7:0] hd);
    load_start = ls;
    host_valid = hv;
    host_data  = hd;
    @(posedge clk);
    model_edge(rst, ls, hv, hd);
    #1;
    check_all();
    load_start = 1'b0;
    host_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic load_bytes(input int gap_lo, input int gap_hi);
    for (int i = 0; i < NW; i++) begin
      idle(int'($urandom_range(gap_hi, gap_lo)));
      cyc(1'b0, 1'b1, 8'($urandom));
    end
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    idle(2);
    rst = 1'b0;

    // normal consecutive load
    cyc(1, 0, 8'h00);
    cyc(0, 1, 8'h11); cyc(0, 1, 8'h22); cyc(0, 1, 8'h33); cyc(0, 1, 8'h44);
    idle(3);

    // gapped load, three idle cycles before each byte
    cyc(1, 0, 8'h00);
    load_bytes(3, 3);
    idle(3);

    // timeout after two bytes
    cyc(1, 0, 8'h00);
    cyc(0, 1, 8'($urandom));
    idle(1);
    cyc(0, 1, 8'($urandom));
    idle(TO + 3);

    // protocol error in IDLE, then a new start clears it
    cyc(0, 1, 8'hAA);
    idle(2);
    cyc(1, 0, 8'h00);
    load_bytes(0, 1);
    idle(2);

    // start coincident with a stray byte
    cyc(1, 1, 8'h5A);
    load_bytes(0, 0);
    idle(2);

    // byte arriving exactly when the timer would expire is accepted
    cyc(1, 0, 8'h00);
    load_bytes(TO - 1, TO - 1);
    idle(2);

    // reset mid-load, then a full load
    cyc(1, 0, 8'h00);
    cyc(0, 1, 8'($urandom));
    cyc(0, 1, 8'($urandom));
    rst = 1'b1;
    cyc(0, 1, 8'($urandom));
    rst = 1'b0;
    cyc(1, 0, 8'h00);
    load_bytes(0, 2);
    idle(1);

    // back-to-back: second start during the load_done cycle
    cyc(1, 0, 8'h00);
    load_bytes(0, 0);
    idle(1);
    cyc(1, 0, 8'h00);
    load_bytes(0, 1);
    idle(3);

    // stray byte during the DONE cycle
    cyc(1, 0, 8'h00);
    load_bytes(0, 0);
    cyc(0, 1, 8'h77);
    idle(2);

    // randomized rounds: stray bytes, random gaps (some long enough to time out), resets, ignored starts
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(3, 0) == 0) cyc(0, 1, 8'($urandom));
      cyc(1, $urandom_range(5, 0) == 0, 8'($urandom));
      for (int i = 0; i < NW; i++) begin
        int g;
        g = ($urandom_range(5, 0) == 0) ? int'($urandom_range(TO + 1, TO - 1))
                                        : int'($urandom_range(2, 0));
        for (int k = 0; k < g; k++) cyc($urandom_range(4, 0) == 0, 0, 8'h00);
        if ($urandom_range(15, 0) == 0) begin
          rst = 1'b1;
          cyc(0, 0, 8'h00);
          rst = 1'b0;
        end
        cyc(0, 1, 8'($urandom));
      end
      idle(int'($urandom_range(3, 1)));
    end
    idle(TO + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
